// File: rtl/unified_mem_arb_if.sv
// unified_mem_arb_if: bundles the CPU fetch port, the CPU data port and the
// single-port RAM port seen by the unified memory arbiter.
//   slave  : the arbiter's view (requests and RAM read data in)
//   master : the environment's view (CPU ports and RAM model)
interface unified_mem_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Instruction-fetch port
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;

  // Data port
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  // Unified RAM port (1-cycle read latency)
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/unified_mem_arb.sv
// unified_mem_arb: shares one synchronous single-port RAM between the CPU
// instruction-fetch port and the CPU data port.
//
// A three-state FSM (IDLE -> ISSUE -> RESP/IDLE) serialises accesses. The
// winner is chosen in IDLE or RESP and latched; ISSUE drives the RAM and the
// grant purely from registers, so no request input reaches a RAM or grant
// output combinationally. RESP flags read data valid for the owner and
// arbitrates again so reads can run back to back every two cycles.
//
// Build option:
//   UNIFIED_MEM_ARB_RR_EN  defined   -> round-robin between the two ports
//                                       when both request together.
//                          undefined -> fixed priority, data over fetch.
module unified_mem_arb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  unified_mem_arb_if.slave bus_io
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Owner encoding: 1 = data port, 0 = fetch port.
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic any_req;
  logic pick_d;

  assign any_req = bus_io.i_req | bus_io.d_req;

`ifdef UNIFIED_MEM_ARB_RR_EN
  // prio_d_q = 1 means the data port wins the next collision. After every
  // grant it points at the port that was not granted.
  logic prio_d_q, prio_d_d;

  // Round-robin preference register; starts favouring the data port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_d_q <= 1'b1;
    else        prio_d_q <= prio_d_d;
  end

  assign pick_d = bus_io.d_req & (~bus_io.i_req | prio_d_q);
`else
  // Fixed priority: any data request beats a fetch. Fetch may starve under
  // a continuous data request; that is accepted behaviour.
  assign pick_d = bus_io.d_req;
`endif

  // State and latched-access registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state logic: arbitrate in IDLE and RESP, issue exactly one access in ISSUE.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef UNIFIED_MEM_ARB_RR_EN
    prio_d_d = prio_d_q;
`endif
    case (state_q)
      ISSUE: begin
        // Writes have no response phase, so they return straight to IDLE.
        state_d = we_q ? IDLE : RESP;
      end
      default: begin
        // IDLE and RESP are both arbitration cycles.
        if (any_req) begin
          state_d = ISSUE;
          owner_d = pick_d ? OWN_D : OWN_I;
          we_d    = pick_d & bus_io.d_we;
          addr_d  = pick_d ? bus_io.d_addr : bus_io.i_addr;
          wdata_d = pick_d ? bus_io.d_wdata : '0;
`ifdef UNIFIED_MEM_ARB_RR_EN
          prio_d_d = ~pick_d;
`endif
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Output decode from registered state only.
  logic in_issue, in_resp;
  assign in_issue = (state_q == ISSUE);
  assign in_resp  = (state_q == RESP);

  assign bus_io.mem_en    = in_issue;
  assign bus_io.mem_we    = in_issue & we_q;
  assign bus_io.mem_addr  = addr_q;
  assign bus_io.mem_wdata = wdata_q;

  assign bus_io.i_gnt    = in_issue & (owner_q == OWN_I);
  assign bus_io.d_gnt    = in_issue & (owner_q == OWN_D);
  assign bus_io.i_rvalid = in_resp  & (owner_q == OWN_I);
  assign bus_io.d_rvalid = in_resp  & (owner_q == OWN_D);

  // Read data is a direct wire from the RAM, qualified by the rvalids.
  assign bus_io.i_rdata = bus_io.mem_rdata;
  assign bus_io.d_rdata = bus_io.mem_rdata;

endmodule

// File: doc/unified_mem_arb.md
# unified_mem_arb

Arbiter and sequencer that shares one synchronous single-port RAM (1-cycle read latency) between the CPU instruction-fetch port and the CPU data port. It sits between the MIPS core's inst/data memory interfaces and a single unified memory, replacing the separate inst/data RAM enables. It serialises accesses through a small FSM with a req/gnt/rvalid handshake and applies fixed or round-robin priority.

## Interface
- AW, 32, address width (byte address, passed through unmodified)
- DW, 32, data width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- i_req  in  1  fetch request; held with i_addr stable until i_gnt
- i_addr  in  AW  fetch address
- i_gnt  out  1  one-cycle pulse: fetch accepted, RAM access issued this cycle
- i_rvalid  out  1  one-cycle pulse: i_rdata valid
- i_rdata  out  DW  fetch data (= mem_rdata; qualified by i_rvalid)
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_gnt  out  1  one-cycle pulse: data access issued this cycle
- d_rvalid  out  1  one-cycle pulse: d_rdata valid (reads only)
- d_rdata  out  DW  read data (= mem_rdata; qualified by d_rvalid)
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid the cycle after a read with mem_en=1

## Operation
- States: IDLE, ISSUE, RESP.
- Arbitration cycles: IDLE and RESP. If any req is high, pick a winner; latch owner, we (forced 0 for I), addr, wdata into registers; next state ISSUE. Otherwise next state IDLE.
- ISSUE: mem_en=1; mem_we/mem_addr/mem_wdata from latched registers; gnt to owner (exactly one of i_gnt/d_gnt). Next: RESP if read, IDLE if write. No arbitration in ISSUE.
- RESP: owner's rvalid=1; rdata = mem_rdata. Arbitration also runs (back-to-back reads).
- Default priority: D over I (a data access of the current instruction completes before the next fetch).
- Outputs are decoded from registered state and latched registers only; no combinational path from any *_req to any mem_* or gnt output. i_rdata/d_rdata are direct wires from mem_rdata.
- Requester's req in RESP is treated as a new request (it was granted in ISSUE).
- A req dropped before gnt is allowed; if it was already latched as winner, the access is still issued and gnt still pulses.

## Timing
- Reset (rst=0, async): state=IDLE, owner=I, latched regs=0, RR pointer=D; all outputs 0 (mem_en, mem_we, mem_addr, mem_wdata, gnts, rvalids; rdata follows mem_rdata but is unqualified).
- Reset mid-access: access abandoned, no rvalid after release; first arbitration is the first IDLE cycle after rst rises.
- Read: req sampled in cycle N (arb cycle) -> gnt + mem_en in N+1 -> rvalid in N+2. Back-to-back reads: one every 2 cycles.
- Write: req in N -> gnt + mem_en + mem_we in N+1 -> IDLE in N+2; next grant earliest N+3.
- Simultaneous i_req and d_req: D wins (default); I is granted at the next arbitration cycle if still requesting.
- Never more than one gnt or rvalid high in a cycle; mem_en high only in ISSUE.

## Configuration
- UNIFIED_MEM_ARB_RR_EN defined: round-robin when both requests are high in an arbitration cycle; the port not granted last wins; pointer updates on every grant; single request always wins regardless of pointer.
- Not defined: fixed D-over-I priority; no pointer register. I may starve under continuous d_req, by design.

## Test plan
- Single fetch: i_req=1, i_addr=0x40 in IDLE cycle 0, RAM[0x40]=0x8C080004 -> cycle 1 i_gnt=1, mem_en=1, mem_we=0, mem_addr=0x40; cycle 2 i_rvalid=1, i_rdata=0x8C080004.
- Data write: d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF -> cycle 1 d_gnt=1, mem_we=1, mem_wdata=0xDEADBEEF; no d_rvalid; subsequent D read of 0x10 returns 0xDEADBEEF two cycles after its arbitration cycle.
- Collision: i_req and d_req (read 0x20) both high cycle 0 -> d_gnt cycle 1, d_rvalid cycle 2, i_gnt cycle 3, i_rvalid cycle 4.
- Back-to-back fetches 0x0,0x4,0x8 with i_req held -> i_gnt at cycles 1,3,5; i_rvalid at 2,4,6 with matching data.
- Reset mid-read: rst=0 during ISSUE -> all outputs 0 immediately, no i_rvalid after release, state IDLE.
- With UNIFIED_MEM_ARB_RR_EN: both reads held continuously -> grants alternate D,I,D,I at cycles 1,3,5,7; without macro all four go to D.
